aes_key_schedule_engine: RTL and testbench

Sequential AES key-expansion engine for AES-128/192/256, selected per key at run time. Accepts one cipher key over a valid/ready handshake and generates the expanded schedule one 32-bit word per cycle through a single 4-sbox SubWord datapath. Streams the 128-bit round keys in order over a second valid/ready handshake. Sits between the key-load interface and the round pipeline, replacing per-round combinational expansion ports.

---
 rtl/aes_key_schedule_engine.sv | 278 +++++++++++++++++++++++++++
 tb/tb_aes_key_schedule_engine.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule_engine.sv
// -----------------------------------------------------------------------------
// aes_key_schedule_engine
//   Sequential AES-128/192/256 key expansion. One cipher key is accepted over a
//   valid/ready handshake. The schedule is generated one 32-bit word per cycle
//   through a single SubWord datapath (4 S-boxes), and each 128-bit round key is
//   streamed in order over a second valid/ready handshake.
//
// Parameters
//   KEY_SIZES_MASK  supported key sizes: bit0=128, bit1=192, bit2=256
//   INDEX_WIDTH     width of Round_key_index (>= 4)
//
// Ports
//   Clk, Rst          clock; synchronous active-high reset
//   Key_size          0=AES-128, 1=AES-192, 2=AES-256, 3=reserved
//   Input_key         cipher key, word j = bits [32j+31:32j]
//   Key_valid/ready   key handshake; ready only while IDLE
//   Abort             drop the current schedule, back to IDLE next cycle
//   Round_key*        round key, its index 0..Nr, last flag, valid/ready
//   Busy              high while generating or draining
//   Error             one-cycle pulse when an offered key is rejected
//
// Build option
//   AES_KEY_SCHEDULE_ZEROIZE_EN  clear word window, staging buffer and
//                                Round_key whenever the engine returns to IDLE
// -----------------------------------------------------------------------------
module aes_key_schedule_engine #(
  parameter logic [2:0]  KEY_SIZES_MASK = 3'b111,
  parameter int unsigned INDEX_WIDTH    = 4
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [1:0]             Key_size,
  input  logic [255:0]           Input_key,
  input  logic                   Key_valid,
  output logic                   Key_ready,
  input  logic                   Abort,
  output logic [127:0]           Round_key,
  output logic [INDEX_WIDTH-1:0] Round_key_index,
  output logic                   Round_key_last,
  output logic                   Round_key_valid,
  input  logic                   Round_key_ready,
  output logic                   Busy,
  output logic                   Error
);

`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as inverse (x^254, which maps 0 to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, sq;
    r  = 8'h01;
    sq = x;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_t                 state_q;
  logic [3:0]             nk_q, nr_q;
  // Last eight schedule words: w[i-1] in slot 7, w[i-Nk] in slot 8-Nk.
  logic [31:0]            win_q [8];
  logic [31:0]            buf_q [4];
  logic [2:0]             cnt_q;
  logic [5:0]             widx_q;
  logic [2:0]             mod_q;
  logic [7:0]             rcon_q;
  logic [127:0]           round_key_q;
  logic [INDEX_WIDTH-1:0] rk_idx_q, next_idx_q;
  logic                   rk_last_q, rk_valid_q, error_q;

  // Key-load decode.
  logic        key_bad;
  logic [3:0]  nk_new, nr_new;
  logic [31:0] load_win [8];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    key_bad  = 1'b1;
    nk_new   = 4'd4;
    nr_new   = 4'd10;
    load_win = '{default: '0};
    case (Key_size)
      2'd0: begin
        key_bad = !KEY_SIZES_MASK[0];
        for (int j = 0; j < 4; j++) load_win[j+4] = Input_key[32*j +: 32];
      end
      2'd1: begin
        key_bad = !KEY_SIZES_MASK[1];
        nk_new  = 4'd6;
        nr_new  = 4'd12;
        for (int j = 0; j < 6; j++) load_win[j+2] = Input_key[32*j +: 32];
      end
      2'd2: begin
        key_bad = !KEY_SIZES_MASK[2];
        nk_new  = 4'd8;
        nr_new  = 4'd14;
        for (int j = 0; j < 8; j++) load_win[j] = Input_key[32*j +: 32];
      end
      default: key_bad = 1'b1;
    endcase
  end

  // Word generation and output-move decode.
  logic         out_free, buf_full, move_held, gen_en, past_key, key_done, move;
  logic         last_word, drain_done;
  logic [31:0]  prev_word, old_word, temp, word_d;
  logic [1:0]   slot;
  logic [127:0] move_data;
  logic [7:0]   rcon_next;

  always_comb begin
    out_free  = !rk_valid_q || Round_key_ready;
    buf_full  = (cnt_q == 3'd4);
    move_held = buf_full && out_free;
    gen_en    = (state_q == GEN) && (!buf_full || out_free);
    past_key  = (widx_q >= {2'b00, nk_q});
    prev_word = win_q[7];
    case (nk_q)
      4'd4:    old_word = win_q[4];
      4'd6:    old_word = win_q[2];
      default: old_word = win_q[0];
    endcase
    // While i<Nk the window slot for w[i-Nk] holds key word i, so XOR with 0.
    temp = '0;
    if (past_key) begin
      if (mod_q == 3'd0)
        temp = sub_word({prev_word[7:0], prev_word[31:8]}) ^ {24'h0, rcon_q};
      else if (nk_q == 4'd8 && mod_q == 3'd4)
        temp = sub_word(prev_word);
      else
        temp = prev_word;
    end
    word_d    = old_word ^ temp;
    // A held full buffer leaves this cycle, so the new word starts slot 0.
    slot      = buf_full ? 2'd0 : cnt_q[1:0];
    // The fourth word of a key bypasses the buffer when the output is free,
    // giving a round key every 4 cycles with no extra pipeline stage.
    key_done  = gen_en && (slot == 2'd3);
    move      = move_held || (key_done && out_free);
    move_data = move_held ? {buf_q[3], buf_q[2], buf_q[1], buf_q[0]}
                          : {word_d, buf_q[2], buf_q[1], buf_q[0]};
    last_word = (widx_q == {nr_q, 2'b11});
    rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    drain_done = (state_q == DRAIN) && (cnt_q == 3'd0) && rk_valid_q
                 && rk_last_q && Round_key_ready;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and later assignments in this block
  // cleanly override earlier ones within the same cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      nk_q        <= 4'd4;
      nr_q        <= 4'd10;
      // NOTE: the window and staging buffer are explicitly cleared on reset so
      // no key material survives a reset, even though the datapath would not
      // otherwise need initial contents.
      win_q       <= '{default: '0};
      buf_q       <= '{default: '0};
      cnt_q       <= '0;
      widx_q      <= '0;
      mod_q       <= '0;
      rcon_q      <= '0;
      round_key_q <= '0;
      rk_idx_q    <= '0;
      next_idx_q  <= '0;
      rk_last_q   <= 1'b0;
      rk_valid_q  <= 1'b0;
      error_q     <= 1'b0;
    end else if (Abort) begin
      state_q    <= IDLE;
      rk_valid_q <= 1'b0;
      cnt_q      <= '0;
      error_q    <= 1'b0;
      if (ZEROIZE) begin
        win_q       <= '{default: '0};
        buf_q       <= '{default: '0};
        round_key_q <= '0;
      end
    end else begin
      error_q <= 1'b0;

      if (rk_valid_q && Round_key_ready) rk_valid_q <= 1'b0;
      if (move) begin
        round_key_q <= move_data;
        rk_idx_q    <= next_idx_q;
        rk_last_q   <= (next_idx_q == INDEX_WIDTH'(nr_q));
        rk_valid_q  <= 1'b1;
        next_idx_q  <= next_idx_q + 1'b1;
      end

      if (move_held) begin
        cnt_q <= gen_en ? 3'd1 : 3'd0;
        if (gen_en) buf_q[0] <= word_d;
      end else if (gen_en) begin
        buf_q[slot] <= word_d;
        if (slot == 2'd3) cnt_q <= out_free ? 3'd0 : 3'd4;
        else              cnt_q <= cnt_q + 3'd1;
      end

      if (gen_en) begin
        for (int j = 0; j < 7; j++) win_q[j] <= win_q[j+1];
        win_q[7] <= word_d;
        widx_q   <= widx_q + 6'd1;
        mod_q    <= (4'(mod_q) + 4'd1 == nk_q) ? 3'd0 : mod_q + 3'd1;
        if (past_key && mod_q == 3'd0) rcon_q <= rcon_next;
        if (last_word) state_q <= DRAIN;
      end

      case (state_q)
        IDLE: begin
          if (Key_valid) begin
            if (key_bad) begin
              error_q <= 1'b1;
            end else begin
              state_q    <= GEN;
              nk_q       <= nk_new;
              nr_q       <= nr_new;
              win_q      <= load_win;
              cnt_q      <= '0;
              widx_q     <= '0;
              mod_q      <= '0;
              rcon_q     <= 8'h01;
              next_idx_q <= '0;
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_q <= IDLE;
            if (ZEROIZE) begin
              win_q       <= '{default: '0};
              buf_q       <= '{default: '0};
              round_key_q <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign Key_ready       = (state_q == IDLE);
  assign Busy            = (state_q != IDLE);
  assign Error           = error_q;
  assign Round_key       = round_key_q;
  assign Round_key_index = rk_idx_q;
  assign Round_key_last  = rk_last_q;
  assign Round_key_valid = rk_valid_q;

endmodule

// File: tb/tb_aes_key_schedule_engine.sv
// -----------------------------------------------------------------------------
// tb_aes_key_schedule_engine
//   Self-checking bench for aes_key_schedule_engine. FIPS-197 vectors come from
//   a table; random keys and random backpressure are checked against a
//   behavioural key-expansion model. Hand sequences cover rejected keys,
//   Abort and a mid-schedule reset. A second instance supports 128/192 only.
// -----------------------------------------------------------------------------
module tb_aes_key_schedule_engine;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, key_valid, key_valid2, abort, rk_ready;
  logic [1:0]   key_size;
  logic [255:0] input_key;

  logic         key_ready, rk_last, rk_valid, busy, error;
  logic [127:0] round_key;
  logic [3:0]   rk_index;

  logic         key_ready2, rk_last2, rk_valid2, busy2, error2;
  logic [127:0] round_key2;
  logic [3:0]   rk_index2;

  aes_key_schedule_engine #(.KEY_SIZES_MASK(3'b111), .INDEX_WIDTH(4)) dut (
    .Clk(clk), .Rst(rst), .Key_size(key_size), .Input_key(input_key),
    .Key_valid(key_valid), .Key_ready(key_ready), .Abort(abort),
    .Round_key(round_key), .Round_key_index(rk_index),
    .Round_key_last(rk_last), .Round_key_valid(rk_valid),
    .Round_key_ready(rk_ready), .Busy(busy), .Error(error)
  );

  aes_key_schedule_engine #(.KEY_SIZES_MASK(3'b011), .INDEX_WIDTH(4)) dut2 (
    .Clk(clk), .Rst(rst), .Key_size(key_size), .Input_key(input_key),
    .Key_valid(key_valid2), .Key_ready(key_ready2), .Abort(abort),
    .Round_key(round_key2), .Round_key_index(rk_index2),
    .Round_key_last(rk_last2), .Round_key_valid(rk_valid2),
    .Round_key_ready(rk_ready), .Busy(busy2), .Error(error2)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [255:0] got,
                       input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- model
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box table built by walking the multiplicative group with generator 3.
  task automatic init_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = sbox_t[t[8*k +: 8]];
    return r;
  endfunction

  logic [31:0] mw [60];
  int          m_nr;

  task automatic model_expand(input logic [1:0] size, input logic [255:0] key);
    logic [7:0]  rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [31:0] t;
    int          nk;
    nk   = 4 + 2 * int'(size);
    m_nr = nk + 6;
    for (int i = 0; i < nk; i++) mw[i] = key[32*i +: 32];
    for (int i = nk; i < 4 * (m_nr + 1); i++) begin
      t = mw[i-1];
      if (i % nk == 0)
        t = subw((t >> 8) | (t << 24)) ^ {24'h0, rc_tab[i/nk - 1]};
      else if (nk == 8 && i % nk == 4)
        t = subw(t);
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  // FIPS-197 text order (first byte leftmost) to byte k at bits [8k+7:8k].
  function automatic logic [255:0] fips(input logic [255:0] v, input int n);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = v[8*(n-1-k) +: 8];
    return r;
  endfunction

  // ------------------------------------------------------------ schedule
  logic [127:0] cap_last;
  int           cap_count;

  task automatic run_schedule(input logic [1:0] size, input logic [255:0] key,
                              input bit rnd, input bit lat);
    int           got, budget;
    int unsigned  a_cyc;
    bit           prev_stall;
    logic [127:0] prev_rk, exp_rk;
    logic [3:0]   prev_idx;
    logic         prev_last;
    model_expand(size, key);
    got        = 0;
    budget     = 0;
    prev_stall = 1'b0;
    prev_rk    = '0;
    prev_idx   = '0;
    prev_last  = 1'b0;
    cap_last   = '0;
    key_size   = size;
    input_key  = key;
    key_valid  = 1'b1;
    rk_ready   = 1'b1;
    check("key_ready_idle", 256'(key_ready), 256'(1));
    step();
    a_cyc     = cyc;
    key_valid = 1'b0;
    while (got <= m_nr && budget < 2000) begin
      rk_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (prev_stall)
        check("rk_hold", 256'({rk_valid, round_key, rk_index, rk_last}),
              256'({1'b1, prev_rk, prev_idx, prev_last}));
      if (rk_valid) begin
        if (lat && !prev_stall)
          check("rk_latency", 256'(cyc - a_cyc), 256'(4 * (got + 1)));
        if (rk_ready) begin
          exp_rk = {mw[4*got+3], mw[4*got+2], mw[4*got+1], mw[4*got]};
          check("rk_data", 256'(round_key), 256'(exp_rk));
          check("rk_index", 256'(rk_index), 256'(got));
          check("rk_last", 256'(rk_last), 256'(got == m_nr));
          cap_last = round_key;
          got++;
        end
      end
      prev_stall = rk_valid && !rk_ready;
      prev_rk    = round_key;
      prev_idx   = rk_index;
      prev_last  = rk_last;
      step();
      budget++;
    end
    if (got <= m_nr) check("schedule_timeout", 256'(got), 256'(m_nr + 1));
    cap_count = got;
    check("key_ready_after_last", 256'({key_ready, busy}), 256'(2'b10));
  endtask

  typedef struct {
    logic [1:0]   size;
    logic [255:0] key;
    int           nkeys;
    logic [127:0] last_key;
    bit           rnd;
  } vec_t;

  vec_t vecs [3];

  initial begin
    logic [255:0] key128, rkey;
    int           waited;
    bit           any_err;

    init_sbox();

    key128 = fips(256'h2b7e151628aed2a6abf7158809cf4f3c, 16);
    vecs[0] = '{size: 2'd0, key: key128, nkeys: 11, rnd: 1'b0,
                last_key: 128'(fips(256'hd014f9a8c9ee2589e13f0cc8b6630ca6, 16))};
    vecs[1] = '{size: 2'd1, nkeys: 13, rnd: 1'b0,
                key: fips(256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 24),
                last_key: 128'(fips(256'he98ba06f448c773c8ecc720401002202, 16))};
    vecs[2] = '{size: 2'd2, nkeys: 15, rnd: 1'b1,
                key: fips(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 32),
                last_key: 128'(fips(256'hfe4890d1e6188d0b046df344706c631e, 16))};

    rst        = 1'b1;
    key_valid  = 1'b0;
    key_valid2 = 1'b0;
    abort      = 1'b0;
    rk_ready   = 1'b0;
    key_size   = 2'd0;
    input_key  = '0;
    step();
    step();
    check("reset_outputs",
          256'({round_key, rk_index, rk_last, rk_valid, busy, error, key_ready}),
          256'({128'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
    rst = 1'b0;
    step();
    check("key_ready_post_reset", 256'(key_ready), 256'(1));

    // FIPS-197 vectors.
    for (int v = 0; v < 3; v++) begin
      run_schedule(vecs[v].size, vecs[v].key, vecs[v].rnd, !vecs[v].rnd);
      check("vec_key_count", 256'(cap_count), 256'(vecs[v].nkeys));
      check("vec_last_key", 256'(cap_last), 256'(vecs[v].last_key));
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
      check("zeroize_round_key", 256'(dut.round_key_q), 256'(0));
      for (int j = 0; j < 8; j++) check("zeroize_window", 256'(dut.win_q[j]), 256'(0));
`endif
    end

    // Reserved key size.
    key_size  = 2'd3;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    check("reserved_error", 256'({error, key_ready, busy, rk_valid}), 256'(4'b1100));
    step();
    check("reserved_error_pulse", 256'({error, key_ready, rk_valid}), 256'(3'b010));

    // AES-256 on an instance built without 256-bit support.
    key_size   = 2'd2;
    key_valid2 = 1'b1;
    step();
    key_valid2 = 1'b0;
    check("mask_error", 256'({error2, key_ready2, busy2, rk_valid2}), 256'(4'b1100));
    step();
    check("mask_error_pulse",
          256'({error2, key_ready2, rk_valid2, round_key2, rk_index2, rk_last2}),
          256'({1'b0, 1'b1, 1'b0, 128'h0, 4'h0, 1'b0}));

    // Abort during round key 5; Key_valid while busy must be ignored.
    key_size  = 2'd0;
    input_key = key128;
    key_valid = 1'b1;
    rk_ready  = 1'b1;
    step();
    key_size  = 2'd3;
    any_err   = 1'b0;
    for (int k = 0; k < 6; k++) begin
      any_err |= error;
      step();
    end
    any_err  |= error;
    key_valid = 1'b0;
    check("busy_key_ignored", 256'({any_err, busy, key_ready}), 256'(3'b010));
    waited = 0;
    while (!(rk_valid && rk_index == 4'd5) && waited < 200) begin
      step();
      waited++;
    end
    check("abort_reach_key5", 256'(rk_valid && rk_index == 4'd5), 256'(1));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_state", 256'({busy, rk_valid, key_ready, error}), 256'(4'b0010));
    run_schedule(2'd0, key128, 1'b0, 1'b1);
    check("post_abort_count", 256'(cap_count), 256'(11));

    // Reset in the middle of an AES-256 schedule.
    key_size  = 2'd2;
    input_key = vecs[2].key;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    for (int k = 0; k < 23; k++) begin
      rk_ready = ($urandom_range(0, 1) != 0);
      step();
    end
    check("busy_before_reset", 256'(busy), 256'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_reset_outputs",
          256'({round_key, rk_index, rk_last, rk_valid, busy, error, key_ready}),
          256'({128'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
    step();

    // Random keys and sizes against the model.
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < 8; k++) rkey[32*k +: 32] = $urandom;
      run_schedule(2'($urandom_range(0, 2)), rkey, (n % 2) == 0, (n % 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
